// File: rtl/ti_share_encoder.sv
// ti_share_encoder: masking front end for the TI S-box datapath.
// Each accepted nibble is split into SHARES Boolean shares. Shares 1..SHARES-1
// are taken from a seeded 32-bit LFSR, and share 0 absorbs the nibble, so the
// XOR of all shares always equals the input. A small FSM owns seeding and
// warm-up. There is one output register stage with a valid/ready handshake.
module ti_share_encoder #(
  parameter int SHARES        = 3,
  parameter int WARMUP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  seed_load,
  input  logic [31:0]           seed,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*SHARES-1:0]   out_shares,
  output logic                  seeded,
  output logic [15:0]           acc_cnt
);

  localparam int WCW = (WARMUP_CYCLES < 2) ? 1 : $clog2(WARMUP_CYCLES + 1);
  localparam logic [WCW-1:0] WLOAD = WCW'(WARMUP_CYCLES);

  localparam logic [1:0] UNSEEDED = 2'd0;
  localparam logic [1:0] WARMUP   = 2'd1;
  localparam logic [1:0] RUN      = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [31:0]         lfsr_q, lfsr_d;
  logic [WCW-1:0]      wcnt_q, wcnt_d;
  logic                ov_q, ov_d;
  logic [4*SHARES-1:0] shares_q, shares_d;
  logic [15:0]         acc_q, acc_d;

  logic [4*SHARES-1:0] shares_new;
  logic                accept;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
  endfunction

  // A seed_load or reset cycle never accepts input, so in_ready is masked by both.
  assign in_ready = (state_q == RUN) & (~ov_q | out_ready) & ~seed_load & ~rst;
  assign accept   = in_valid & in_ready;

  // Build the share word from the pre-step LFSR value; share 0 folds in the nibble.
  always_comb begin
    logic [3:0] mask_x;
    mask_x     = '0;
    shares_new = '0;
    for (int i = 1; i < SHARES; i++) begin
      shares_new[4*i +: 4] = lfsr_q[4*(i-1) +: 4];
      mask_x               = mask_x ^ lfsr_q[4*(i-1) +: 4];
    end
    shares_new[3:0] = in_data ^ mask_x;
  end

  // Next-state logic: seed_load preempts the FSM. In RUN the LFSR only steps on accept.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    wcnt_d   = wcnt_q;
    ov_d     = ov_q;
    shares_d = shares_q;
    acc_d    = acc_q;
    if (seed_load) begin
      lfsr_d  = (seed == '0) ? 32'h0000_0001 : seed;
      wcnt_d  = WLOAD;
      ov_d    = 1'b0;
      state_d = (WARMUP_CYCLES == 0) ? RUN : WARMUP;
    end else begin
      case (state_q)
        UNSEEDED: ;
        WARMUP: begin
          lfsr_d = lfsr_step(lfsr_q);
          if (wcnt_q <= WCW'(1)) begin
            wcnt_d  = '0;
            state_d = RUN;
          end else begin
            wcnt_d = wcnt_q - WCW'(1);
          end
        end
        RUN: begin
          if (accept) begin
            shares_d = shares_new;
            ov_d     = 1'b1;
            lfsr_d   = lfsr_step(lfsr_q);
            acc_d    = acc_q + 16'd1;
          end else if (out_ready) begin
            ov_d = 1'b0;
          end
        end
        default: state_d = UNSEEDED;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= UNSEEDED;
      lfsr_q   <= '0;
      wcnt_q   <= '0;
      ov_q     <= 1'b0;
      shares_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      wcnt_q   <= wcnt_d;
      ov_q     <= ov_d;
      shares_q <= shares_d;
      acc_q    <= acc_d;
    end
  end

  assign out_valid  = ov_q;
  assign out_shares = shares_q;
  assign seeded     = (state_q == RUN);
  assign acc_cnt    = acc_q;

endmodule

// File: tb/tb_ti_share_encoder.sv
// Directed bench for ti_share_encoder with SHARES=3 and WARMUP_CYCLES=4.
// Expected share words come from LFSR values computed by hand starting at seed 1:
// 0x1B, 0x36, 0x6D, 0xDB, 0x1B6.
module tb_ti_share_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seed_load = 1'b0;
  logic [31:0] seed = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_shares;
  logic        seeded;
  logic [15:0] acc_cnt;

  int checks = 0;
  int errors = 0;

  ti_share_encoder #(.SHARES(3), .WARMUP_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_shares(out_shares),
    .seeded(seeded), .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic logic [3:0] xs(input logic [11:0] w);
    return w[3:0] ^ w[7:4] ^ w[11:8];
  endfunction

  task automatic test_reset;
    rst = 1'b1; in_data = 4'bxxxx;
    tick; tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_ov got %b want 0", out_valid); end
    checks++; if (out_shares !== 12'h000) begin errors++; $display("FAIL rst_shares got %h want 000", out_shares); end
    checks++; if (seeded !== 1'b0) begin errors++; $display("FAIL rst_seeded got %b want 0", seeded); end
    checks++; if (acc_cnt !== 16'h0) begin errors++; $display("FAIL rst_acc got %h want 0", acc_cnt); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ir got %b want 0", in_ready); end
    rst = 1'b0; in_valid = 1'b1; in_data = 4'h3;
    tick;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL unseeded_ir got %b want 0", in_ready); end
    in_valid = 1'b0;
  endtask

  // Seed, warm up, accept nibble 5 and expect 0x1BF.
  task automatic test_seed(input logic [31:0] s, input logic [15:0] exp_acc, input logic drain);
    seed_load = 1'b1; seed = s; in_valid = 1'b1; in_data = 4'h5; out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL load_ir got %b want 0", in_ready); end
    tick;
    seed_load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (in_ready !== 1'b0 || seeded !== 1'b0) begin errors++; $display("FAIL warm_ir%0d got %b/%b want 0/0", k, in_ready, seeded); end
      tick;
    end
    checks++; if (seeded !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL run_ir got %b/%b want 1/1", seeded, in_ready); end
    tick;
    in_valid = 1'b0; in_data = 4'bxxxx;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL seed_ov got %b want 1", out_valid); end
    checks++; if (out_shares !== 12'h1BF) begin errors++; $display("FAIL seed_word got %h want 1bf", out_shares); end
    checks++; if (acc_cnt !== exp_acc) begin errors++; $display("FAIL seed_acc got %h want %h", acc_cnt, exp_acc); end
    if (drain) begin
      out_ready = 1'b1;
      tick;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_ov got %b want 0", out_valid); end
      checks++; if (out_shares !== 12'h1BF) begin errors++; $display("FAIL drain_hold got %h want 1bf", out_shares); end
      out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure;
    logic [3:0]  d [3];
    logic [11:0] w [3];
    d = '{4'hA, 4'h0, 4'h3};
    w = '{12'h36F, 12'h6DB, 12'hDB5};
    in_valid = 1'b1; in_data = 4'hA; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_shares !== 12'h1BF) begin
        errors++; $display("FAIL bp_hold%0d got ir=%b ov=%b w=%h want 0/1/1bf", k, in_ready, out_valid, out_shares); end
      tick;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = d[k];
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ir%0d got %b want 1", k, in_ready); end
      tick;
      checks++; if (out_valid !== 1'b1 || out_shares !== w[k]) begin
        errors++; $display("FAIL bp_word%0d got %b/%h want 1/%h", k, out_valid, out_shares, w[k]); end
    end
    in_valid = 1'b0;
    tick;
    checks++; if (out_valid !== 1'b0 || acc_cnt !== 16'd5) begin errors++; $display("FAIL bp_end got %b/%0d want 0/5", out_valid, acc_cnt); end
  endtask

  task automatic test_seed_reload;
    in_valid = 1'b1; in_data = 4'h7; out_ready = 1'b0;
    tick;
    checks++; if (out_shares !== 12'hB6A) begin errors++; $display("FAIL rl_word got %h want b6a", out_shares); end
    seed_load = 1'b1; seed = 32'h1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rl_ir got %b want 0", in_ready); end
    tick;
    seed_load = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || acc_cnt !== 16'd6) begin errors++; $display("FAIL rl_drop got %b/%0d want 0/6", out_valid, acc_cnt); end
    in_data = 4'h5;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rl_warm%0d got %b want 0", k, in_ready); end
      tick;
    end
    tick;
    in_valid = 1'b0;
    checks++; if (out_shares !== 12'h1BF || acc_cnt !== 16'd7) begin errors++; $display("FAIL rl_word2 got %h/%0d want 1bf/7", out_shares, acc_cnt); end
  endtask

  task automatic test_rst_midstream;
    in_valid = 1'b1; out_ready = 1'b1; in_data = 4'h9; rst = 1'b1;
    tick;
    checks++; if (out_valid !== 1'b0 || out_shares !== 12'h0 || seeded !== 1'b0 || acc_cnt !== 16'h0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_rst got ov=%b w=%h s=%b acc=%h ir=%b want all 0", out_valid, out_shares, seeded, acc_cnt, in_ready); end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_idle%0d got %b/%b want 0/0", k, in_ready, out_valid); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random;
    logic [3:0] q [$];
    logic [3:0] e;
    int n_acc = 0;
    int guard = 0;
    seed_load = 1'b1; seed = 32'hACE1_2345;
    tick;
    seed_load = 1'b0;
    while (!seeded && guard < 20) begin tick; guard++; end
    checks++; if (seeded !== 1'b1) begin errors++; $display("FAIL rnd_seed got %b want 1", seeded); end
    guard = 0;
    while (n_acc < 65536 && guard < 70000) begin
      if (guard < 400) begin
        in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b1; out_ready = 1'b1;
      end
      in_data = in_valid ? 4'($urandom_range(0, 15)) : 4'bxxxx;
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL rnd_extra word %h with empty scoreboard", out_shares); end
        else begin
          e = q.pop_front();
          if (xs(out_shares) !== e) begin errors++; $display("FAIL rnd_xor got %h want %h", xs(out_shares), e); end
        end
      end
      checks++; if (in_ready !== (!out_valid || out_ready)) begin errors++; $display("FAIL rnd_ir got %b want %b", in_ready, !out_valid || out_ready); end
      if (in_valid && in_ready) begin q.push_back(in_data); n_acc++; end
      tick;
      guard++;
      if (guard == 400) begin
        checks++; if (acc_cnt !== 16'(n_acc)) begin errors++; $display("FAIL rnd_acc got %0d want %0d", acc_cnt, n_acc); end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (n_acc != 65536 || acc_cnt !== 16'h0000) begin errors++; $display("FAIL rnd_wrap got acc=%h n=%0d want 0/65536", acc_cnt, n_acc); end
    #1;
    if (out_valid) begin
      checks++;
      e = (q.size() != 0) ? q.pop_front() : 4'bxxxx;
      if (xs(out_shares) !== e) begin errors++; $display("FAIL rnd_last got %h want %h", xs(out_shares), e); end
    end
    tick;
    checks++; if (out_valid !== 1'b0 || q.size() != 0) begin errors++; $display("FAIL rnd_empty got ov=%b q=%0d want 0/0", out_valid, q.size()); end
  endtask

  initial begin
    test_reset;
    test_seed(32'h0000_0001, 16'd1, 1'b1);
    test_seed(32'h0000_0000, 16'd2, 1'b0);
    test_backpressure;
    test_seed_reload;
    test_rst_midstream;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
